// File: rtl/fetch_ifid.sv
// fetch_ifid: fetch-stage PC and IF/ID register with stall, flush and HALT freeze; ports clk, rst, stall, flush, redirect_pc, halt_dec, imem_addr, imem_rdata -> instruction, currPC, new_addr, if_valid, halted
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  input  logic        halt_dec,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] currPC,
  output logic [15:0] new_addr,
  output logic        if_valid,
  output logic        halted
);
  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;
  state_t      state_q;
  logic [15:0] pc_q, instr_q, cur_q, new_q, pc_d;
  logic        valid_q, halted_q, fetch_halt;
  assign pc_d        = pc_q + 16'd2;
  assign fetch_halt  = imem_rdata[15:11] == 5'b00000;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign currPC      = cur_q;
  assign new_addr    = new_q;
  assign if_valid    = valid_q;
  assign halted      = halted_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      cur_q    <= 16'h0000;
      new_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (state_q != HALTED) begin
      if (flush) begin
        state_q <= RUN;
        pc_q    <= redirect_pc;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (state_q == HALT_PEND) begin
        if (halt_dec && !stall) begin
          state_q  <= HALTED;
          instr_q  <= NOP_INSTR;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
      end else if (!stall) begin
        state_q <= fetch_halt ? HALT_PEND : RUN;
        pc_q    <= pc_d;
        instr_q <= imem_rdata;
        cur_q   <= pc_q;
        new_q   <= pc_d;
        valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ifid.sv
// tb_fetch_ifid: randomized scoreboard bench for fetch_ifid against a behavioural model
module tb_fetch_ifid;
  logic        clk = 0, rst = 1, stall = 0, flush = 0, halt_dec = 0;
  logic [15:0] redirect_pc = 0, imem_rdata, imem_addr, instruction, currPC, new_addr;
  logic        if_valid, halted;
  logic [15:0] mem [0:255];
  typedef struct packed {
    logic [15:0] pc, instr, cur, nw;
    logic        valid, halted;
  } exp_t;
  exp_t sb[$];
  exp_t m, e;
  logic m_pend;
  int   n_chk = 0, n_pass = 0;
  fetch_ifid dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .halt_dec(halt_dec), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .currPC(currPC), .new_addr(new_addr),
    .if_valid(if_valid), .halted(halted)
  );
  assign imem_rdata = mem[imem_addr[8:1]];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
  endtask
  task automatic fill_seq;
    for (int k = 0; k < 256; k++) mem[k] = 16'h4001 + 16'(k);
  endtask
  task automatic fill_rand;
    for (int k = 0; k < 256; k++) mem[k] = ($urandom % 10 == 0) ? 16'h0000 : 16'($urandom);
  endtask
  task automatic step(input logic r, s, f, input logic [15:0] rp, input logic hd);
    logic [15:0] rd;
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_pc = rp; halt_dec = hd;
    rd = mem[m.pc[8:1]];
    if (r) begin
      m = '{pc: 16'h0000, instr: 16'h0800, cur: 16'h0000, nw: 16'h0000, valid: 1'b0, halted: 1'b0};
      m_pend = 1'b0;
    end else if (m.halted) begin
    end else if (f) begin
      m.pc = rp; m.instr = 16'h0800; m.valid = 1'b0; m_pend = 1'b0;
    end else if (m_pend) begin
      if (hd && !s) begin
        m.instr = 16'h0800; m.valid = 1'b0; m.halted = 1'b1; m_pend = 1'b0;
      end
    end else if (!s) begin
      m.instr = rd; m.cur = m.pc; m.nw = m.pc + 16'd2; m.valid = 1'b1;
      m.pc = m.pc + 16'd2;
      m_pend = (rd >> 11) == 16'd0;
    end
    sb.push_back(m);
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_pc", imem_addr, e.pc);
      chk("sb_instr", instruction, e.instr);
      chk("sb_currPC", currPC, e.cur);
      chk("sb_new_addr", new_addr, e.nw);
      chk("sb_valid", 16'(if_valid), 16'(e.valid));
      chk("sb_halted", 16'(halted), 16'(e.halted));
    end
  end
  initial begin
    fill_seq;
    step(1, 0, 0, 0, 0);
    chk("rst_pc", imem_addr, 16'h0000);
    chk("rst_instr", instruction, 16'h0800);
    chk("rst_valid", 16'(if_valid), 16'd0);
    step(0, 0, 0, 0, 0);
    chk("t1_instr0", instruction, 16'h4001);
    chk("t1_cur0", currPC, 16'h0000);
    chk("t1_new0", new_addr, 16'h0002);
    step(0, 0, 0, 0, 0);
    chk("t1_instr1", instruction, 16'h4002);
    chk("t1_cur1", currPC, 16'h0002);
    chk("t1_new1", new_addr, 16'h0004);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0);
      chk("t2_stall_pc", imem_addr, 16'h0008);
      chk("t2_stall_instr", instruction, 16'h4004);
    end
    step(0, 0, 0, 0, 0);
    chk("t2_resume", instruction, 16'h4005);
    step(0, 1, 1, 16'h0040, 0);
    chk("t3_nop", instruction, 16'h0800);
    chk("t3_valid", 16'(if_valid), 16'd0);
    step(0, 0, 0, 0, 0);
    chk("t3_cur", currPC, 16'h0040);
    chk("t3_instr", instruction, 16'h4021);
    step(1, 0, 0, 0, 0);
    mem[3] = 16'h0000;
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t4_halted", 16'(halted), 16'd1);
    for (int k = 0; k < 22; k++) begin
      step(0, k % 3 == 0, k % 2 == 0, 16'h0040, 1);
      chk("t4_pc", imem_addr, 16'h0008);
      chk("t4_instr", instruction, 16'h0800);
    end
    step(1, 0, 0, 0, 0);
    fill_seq;
    mem[1] = 16'h0000;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 16'h0010, 0);
    chk("t5_not_halted", 16'(halted), 16'd0);
    step(0, 0, 0, 0, 1);
    chk("t5_cur", currPC, 16'h0010);
    chk("t5_instr", instruction, 16'h4009);
    step(0, 0, 1, 16'hFFFE, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_new_wrap", new_addr, 16'h0000);
    chk("t6_pc_wrap", imem_addr, 16'h0000);
    chk("t6_cur", currPC, 16'hFFFE);
    mem[0] = 16'h0000;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_pend_frozen", imem_addr, 16'h0002);
    step(1, 0, 1, 16'h0100, 1);
    chk("t6_rst_pc", imem_addr, 16'h0000);
    chk("t6_rst_halted", 16'(halted), 16'd0);
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 0) fill_rand;
      step(m.halted ? ($urandom % 20 == 0) : ($urandom % 80 == 0), $urandom % 4 == 0,
           $urandom % 8 == 0, 16'($urandom_range(0, 600)), $urandom % 3 != 0);
    end
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
